bundle_issue: RTL and testbench

Instruction-bundle issue stage placed directly upstream of `vliw_top`. It buffers 64-bit VLIW instruction words, paired with their 192-bit immediate/load data, in a small FIFO supplied by a producer (instruction memory or testbench loader). It presents exactly one bundle per clock on the core's `word`/`data` inputs, and substitutes a NOP bundle when the queue is empty. When the core asserts `jump`, all queued bundles are discarded.

---
 rtl/vliw_pkg.sv | 16 +
 rtl/bundle_fifo.sv | 78 +++++++
 rtl/bundle_issue.sv | 88 ++++++++
 tb/tb_bundle_issue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/vliw_pkg.sv
// Shared widths, NOP encoding and the bundle record used by the VLIW
// front end.
package vliw_pkg;

  localparam int unsigned WORD_W   = 64;
  localparam int unsigned DATA_W   = 192;
  localparam int unsigned BUNDLE_W = WORD_W + DATA_W;

  localparam logic [WORD_W-1:0] NOP_WORD = 64'h0;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [DATA_W-1:0] data;
  } bundle_t;

endpackage

// File: rtl/bundle_fifo.sv
// DEPTH-entry synchronous bundle FIFO with flush, occupancy count and
// registered empty/full flags.
module bundle_fifo
  import vliw_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  bundle_t                wdata_i,
  output bundle_t                rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  bundle_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic               empty_q, full_q;
  logic               push_ok, pop_ok;

  assign push_ok = push_i && !full_q && !clear_i;
  assign pop_ok  = pop_i && !empty_q && !clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == OCC_W'(DEPTH));
    end
  end

  // Storage needs no reset; contents are only read when count_q > 0.
  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/bundle_issue.sv
// Issue stage ahead of vliw_top: queues {word,data} bundles and presents one
// registered bundle per clock, substituting a NOP when nothing is queued.
module bundle_issue
  import vliw_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic [DATA_W-1:0] in_data,
  input  logic              jump,
  output logic [WORD_W-1:0] word,
  output logic [DATA_W-1:0] data,
  output logic              issue_valid,
  output logic              empty,
  output logic [CNT_W-1:0]  issue_count
);

  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic             push, pop;
  logic             fifo_full;
  logic [OCC_W-1:0] fifo_count;
  bundle_t          head, wr_bundle;

  logic [WORD_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Full blocks the producer even in a popping cycle; no ready-through-pop path.
  assign in_ready  = !fifo_full && !jump;
  assign push      = in_valid && in_ready;
  assign pop       = (fifo_count != '0) && !jump;
  assign wr_bundle = {in_word, in_data};

  bundle_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .clear_i (jump),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_bundle),
    .rdata_o (head),
    .count_o (fifo_count),
    .empty_o (empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    word_d  = NOP_WORD;
    data_d  = '0;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    if (pop) begin
      word_d  = head.word;
      data_d  = head.data;
      valid_d = 1'b1;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word_q  <= NOP_WORD;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      word_q  <= word_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word        = word_q;
  assign data        = data_q;
  assign issue_valid = valid_q;
  assign issue_count = cnt_q;

endmodule

// File: tb/tb_bundle_issue.sv
// Directed self-checking bench for bundle_issue; counter width reduced so the
// wrap can be reached in a few hundred cycles.
module tb_bundle_issue;

  localparam int unsigned CW = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [63:0]    in_word;
  logic [191:0]   in_data;
  logic           jump;
  logic [63:0]    word;
  logic [191:0]   data;
  logic           issue_valid;
  logic           empty;
  logic [CW-1:0]  issue_count;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  bundle_issue #(
    .DEPTH(4),
    .CNT_W(CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_word     (in_word),
    .in_data     (in_data),
    .jump        (jump),
    .word        (word),
    .data        (data),
    .issue_valid (issue_valid),
    .empty       (empty),
    .issue_count (issue_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; jump = 1'b0; in_word = '0; in_data = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick(); tick(); tick();
    total_cnt++; if (word !== 64'h0) $display("FAIL reset_word got=%h exp=0", word); else pass_cnt++;
    total_cnt++; if (data !== 192'h0) $display("FAIL reset_data got=%h exp=0", data); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", issue_valid); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", empty); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", in_ready); else pass_cnt++;
    total_cnt++; if (issue_count !== 8'h00) $display("FAIL reset_count got=%h exp=00", issue_count); else pass_cnt++;
  endtask

  task automatic test_single();
    logic [63:0]  ew;
    logic [191:0] ed;
    ew = 64'h0000_0000_0012_3456;
    ed = {64'h3, 64'h2, 64'h1};
    do_reset();
    in_valid = 1'b1; in_word = ew; in_data = ed;
    tick();
    in_valid = 1'b0;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL single_nobypass got=%b exp=0", issue_valid); else pass_cnt++;
    total_cnt++; if (empty !== 1'b0) $display("FAIL single_empty got=%b exp=0", empty); else pass_cnt++;
    tick();
    total_cnt++; if (word !== ew) $display("FAIL single_word got=%h exp=%h", word, ew); else pass_cnt++;
    total_cnt++; if (data !== ed) $display("FAIL single_data got=%h exp=%h", data, ed); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", issue_valid); else pass_cnt++;
    total_cnt++; if (issue_count !== 8'd1) $display("FAIL single_count got=%0d exp=1", issue_count); else pass_cnt++;
    tick();
    total_cnt++; if (word !== 64'h0) $display("FAIL single_nop_word got=%h exp=0", word); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL single_nop_valid got=%b exp=0", issue_valid); else pass_cnt++;
    total_cnt++; if (issue_count !== 8'd1) $display("FAIL single_count_hold got=%0d exp=1", issue_count); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [63:0]  ew;
    logic [191:0] ed;
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1;
      in_word  = 64'(i);
      in_data  = {64'(i + 200), 64'(i + 100), 64'(i)};
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL burst_ready[%0d] got=%b exp=1", i, in_ready); else pass_cnt++;
      tick();
      if (i >= 2) begin
        ew = 64'(i - 1);
        ed = {64'(i - 1 + 200), 64'(i - 1 + 100), 64'(i - 1)};
        total_cnt++; if (word !== ew) $display("FAIL burst_word[%0d] got=%h exp=%h", i, word, ew); else pass_cnt++;
        total_cnt++; if (data !== ed) $display("FAIL burst_data[%0d] got=%h exp=%h", i, data, ed); else pass_cnt++;
        total_cnt++; if (issue_valid !== 1'b1) $display("FAIL burst_valid[%0d] got=%b exp=1", i, issue_valid); else pass_cnt++;
      end
    end
    in_valid = 1'b0;
    tick();
    total_cnt++; if (word !== 64'd6) $display("FAIL burst_last_word got=%h exp=6", word); else pass_cnt++;
    total_cnt++; if (issue_count !== 8'd6) $display("FAIL burst_count got=%0d exp=6", issue_count); else pass_cnt++;
    tick();
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL burst_drain got=%b exp=0", issue_valid); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1) $display("FAIL burst_empty got=%b exp=1", empty); else pass_cnt++;
  endtask

  task automatic test_jump_hold();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      jump = 1'b1; in_valid = 1'b1; in_word = 64'(i + 10); in_data = '0;
      #1;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL jumphold_ready[%0d] got=%b exp=0", i, in_ready); else pass_cnt++;
      tick();
      total_cnt++; if (empty !== 1'b1) $display("FAIL jumphold_empty[%0d] got=%b exp=1", i, empty); else pass_cnt++;
    end
    jump = 1'b0; in_valid = 1'b0;
    tick();
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL jumphold_valid got=%b exp=0", issue_valid); else pass_cnt++;
    total_cnt++; if (issue_count !== 8'd0) $display("FAIL jumphold_count got=%0d exp=0", issue_count); else pass_cnt++;
  endtask

  task automatic test_jump_flush();
    do_reset();
    in_valid = 1'b1; in_word = 64'hA1; in_data = 192'h1;
    tick();
    in_word = 64'hB2; in_data = 192'h2;
    tick();
    total_cnt++; if (word !== 64'hA1) $display("FAIL flush_prev_word got=%h exp=a1", word); else pass_cnt++;
    jump = 1'b1; in_word = 64'hC3; in_data = 192'h3;
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_ready got=%b exp=0", in_ready); else pass_cnt++;
    tick();
    jump = 1'b0; in_valid = 1'b0;
    total_cnt++; if (word !== 64'h0) $display("FAIL flush_word got=%h exp=0", word); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL flush_valid got=%b exp=0", issue_valid); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1) $display("FAIL flush_empty got=%b exp=1", empty); else pass_cnt++;
    tick();
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL flush_discard got=%b exp=0", issue_valid); else pass_cnt++;
    in_valid = 1'b1; in_word = 64'hAA; in_data = 192'hAA;
    tick();
    in_valid = 1'b0;
    tick();
    total_cnt++; if (word !== 64'hAA) $display("FAIL flush_after_word got=%h exp=aa", word); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b1) $display("FAIL flush_after_valid got=%b exp=1", issue_valid); else pass_cnt++;
    total_cnt++; if (issue_count !== 8'd2) $display("FAIL flush_count got=%0d exp=2", issue_count); else pass_cnt++;
  endtask

  task automatic test_count_wrap();
    do_reset();
    in_valid = 1'b1; in_data = '0;
    for (int i = 0; i < 256; i++) begin
      in_word = 64'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    total_cnt++; if (issue_count !== 8'hFF) $display("FAIL wrap_max got=%h exp=ff", issue_count); else pass_cnt++;
    tick();
    total_cnt++; if (issue_count !== 8'h00) $display("FAIL wrap_zero got=%h exp=00", issue_count); else pass_cnt++;
    total_cnt++; if (word !== 64'd256) $display("FAIL wrap_word got=%h exp=100", word); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_word = 64'(i); in_data = 192'(i);
      tick();
    end
    total_cnt++; if (word !== 64'd2) $display("FAIL midrst_pre_word got=%h exp=2", word); else pass_cnt++;
    reset = 1'b1; in_word = 64'd4; in_data = 192'd4;
    tick();
    total_cnt++; if (word !== 64'h0) $display("FAIL midrst_word got=%h exp=0", word); else pass_cnt++;
    total_cnt++; if (data !== 192'h0) $display("FAIL midrst_data got=%h exp=0", data); else pass_cnt++;
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", issue_valid); else pass_cnt++;
    total_cnt++; if (issue_count !== 8'd0) $display("FAIL midrst_count got=%0d exp=0", issue_count); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1) $display("FAIL midrst_empty got=%b exp=1", empty); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL midrst_ready got=%b exp=1", in_ready); else pass_cnt++;
    reset = 1'b0; in_valid = 1'b0;
    tick();
    total_cnt++; if (issue_valid !== 1'b0) $display("FAIL midrst_after_valid got=%b exp=0", issue_valid); else pass_cnt++;
    total_cnt++; if (word !== 64'h0) $display("FAIL midrst_after_word got=%h exp=0", word); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_jump_hold();
    test_jump_flush();
    test_count_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
